// File: rtl/xm_mc_pkg.sv
// Shared types and constants for the X-Makina multi-cycle controller.
package xm_mc_pkg;

  // Controller states. The encoding is fixed so it can be matched in waveforms.
  typedef enum logic [4:0] {
    ST_EXC_CHECK     = 5'd0,
    ST_FETCH         = 5'd1,
    ST_FETCH_WAIT    = 5'd2,
    ST_DECODE        = 5'd3,
    ST_COND_BRANCH   = 5'd4,
    ST_LINK_BRANCH   = 5'd5,
    ST_ALU           = 5'd6,
    ST_IMM_LOAD      = 5'd7,
    ST_LOAD          = 5'd8,
    ST_STORE         = 5'd9,
    ST_MEM_WAIT      = 5'd10,
    ST_MEM_WRITEBACK = 5'd11,
    ST_SWAP          = 5'd12,
    ST_SWAP_2        = 5'd13,
    ST_EXC_ENTRY     = 5'd14,
    ST_EXC_RETURN    = 5'd15,
    ST_INT_ENABLE    = 5'd16,
    ST_INT_DISABLE   = 5'd17,
    ST_BREAK         = 5'd18
  } state_e;

  // Instruction classes delivered by the decoder; codes 11..15 are undefined.
  typedef enum logic [3:0] {
    CLS_ALU         = 4'd0,
    CLS_IMM_LOAD    = 4'd1,
    CLS_COND_BRANCH = 4'd2,
    CLS_LINK_BRANCH = 4'd3,
    CLS_LOAD        = 4'd4,
    CLS_STORE       = 4'd5,
    CLS_SWAP        = 4'd6,
    CLS_RETI        = 4'd7,
    CLS_INT_ENABLE  = 4'd8,
    CLS_INT_DISABLE = 4'd9,
    CLS_BREAK       = 4'd10
  } inst_class_e;

  // ALU operand B source
  localparam logic [1:0] ALU_B_REG     = 2'd0;
  localparam logic [1:0] ALU_B_CONST   = 2'd1;
  localparam logic [1:0] ALU_B_MEM     = 2'd2;

  // Register file write-data source
  localparam logic [2:0] REG_WR_ALU    = 3'd0;
  localparam logic [2:0] REG_WR_PC     = 3'd1;
  localparam logic [2:0] REG_WR_MEM    = 3'd2;
  localparam logic [2:0] REG_WR_IMM    = 3'd3;
  localparam logic [2:0] REG_WR_TEMP   = 3'd4;

  // Next-PC source
  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_VECTOR = 2'd2;
  localparam logic [1:0] PC_SRC_EPC    = 2'd3;

  // Exception cause codes (interrupts use their line index 0..7)
  localparam logic [3:0] EXC_ILLEGAL   = 4'd8;
  localparam logic [3:0] EXC_BUSFAULT  = 4'd9;

endpackage

// File: rtl/xm_mc_controller_irq_prio.sv
// Fixed-priority interrupt encoder: lowest-numbered active request wins.
module xm_irq_prio #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [3:0]         o_idx,
  output logic               o_valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop; without it a
    // path that assigns nothing would infer a latch.
    o_idx   = 4'd0;
    o_valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xm_mc_controller.sv
// Multi-cycle control FSM for the X-Makina core: fetch, decode, execute,
// memory handshake with timeout, exceptions and exception return.
module xm_mc_controller
  import xm_mc_pkg::*;
#(
  parameter int WORD        = 16,
  parameter int LR          = 5,
  parameter int NUM_IRQ     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               memBusy_i,
  input  logic [3:0]         instClass_i,
  input  logic               branchRes_i,
  input  logic               constSel_i,
  input  logic               byteOp_i,
  input  logic [2:0]         regAdrA_i,
  input  logic [2:0]         regAdrB_i,
  input  logic [3:0]         aluOp_i,
  input  logic [WORD-1:0]    condOffset_i,
  input  logic [WORD-1:0]    jumpOffset_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               pcWr_o,
  output logic               regWr_o,
  output logic               irWr_o,
  output logic               memEn_o,
  output logic               memRW_o,
  output logic               byteOp_o,
  output logic [1:0]         pcSrc_o,
  output logic [1:0]         aluBSel_o,
  output logic [2:0]         regWrSel_o,
  output logic [2:0]         regWrAdr_o,
  output logic [2:0]         regAdrA_o,
  output logic [2:0]         regAdrB_o,
  output logic [3:0]         aluOp_o,
  output logic [WORD-1:0]    branchOffs_o,
  output logic               tempWr_o,
  output logic [3:0]         excVec_o,
  output logic               epcWr_o,
  output logic               intEn_o
);

  localparam logic [2:0] LR_ADR      = 3'(LR);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_e      r_state;
  logic        r_int_en;
  logic [7:0]  r_cnt;
  logic [3:0]  r_exc_vec;
  logic        r_is_store;

  logic [3:0]  w_irq_idx;
  logic        w_irq_valid;
  logic [7:0]  w_cnt_inc;

  xm_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_irq_prio (
    .i_req   (irq_i),
    .o_idx   (w_irq_idx),
    .o_valid (w_irq_valid)
  );

  assign w_cnt_inc = r_cnt + 8'd1;
  assign intEn_o   = r_int_en;
  assign excVec_o  = r_exc_vec;
  assign regAdrA_o = regAdrA_i;
  assign regAdrB_o = regAdrB_i;

  // State sequencing plus the registered interrupt enable, cause and timeout counter.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state    <= ST_EXC_CHECK;
      r_int_en   <= 1'b0;
      r_cnt      <= 8'd0;
      r_exc_vec  <= 4'd0;
      r_is_store <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // branch below reads the values from before this clock edge.
      unique case (r_state)
        ST_EXC_CHECK: begin
          if (r_int_en && w_irq_valid) begin
            r_exc_vec <= w_irq_idx;
            r_state   <= ST_EXC_ENTRY;
          end else begin
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_cnt   <= 8'd0;
          r_state <= ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT, ST_MEM_WAIT: begin
          if (memBusy_i) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == TIMEOUT_CNT) begin
              r_exc_vec <= EXC_BUSFAULT;
              r_state   <= ST_EXC_ENTRY;
            end
          end else if (r_state == ST_FETCH_WAIT) begin
            r_state <= ST_DECODE;
          end else if (r_is_store) begin
            r_state <= ST_EXC_CHECK;
          end else begin
            r_state <= ST_MEM_WRITEBACK;
          end
        end
        ST_DECODE: begin
          case (instClass_i)
            CLS_ALU:         r_state <= ST_ALU;
            CLS_IMM_LOAD:    r_state <= ST_IMM_LOAD;
            CLS_COND_BRANCH: r_state <= ST_COND_BRANCH;
            CLS_LINK_BRANCH: r_state <= ST_LINK_BRANCH;
            CLS_LOAD:        r_state <= ST_LOAD;
            CLS_STORE:       r_state <= ST_STORE;
            CLS_SWAP:        r_state <= ST_SWAP;
            CLS_RETI:        r_state <= ST_EXC_RETURN;
            CLS_INT_ENABLE:  r_state <= ST_INT_ENABLE;
            CLS_INT_DISABLE: r_state <= ST_INT_DISABLE;
            CLS_BREAK:       r_state <= ST_BREAK;
            default: begin
              r_exc_vec <= EXC_ILLEGAL;
              r_state   <= ST_EXC_ENTRY;
            end
          endcase
        end
        ST_LOAD, ST_STORE: begin
          r_cnt      <= 8'd0;
          r_is_store <= (r_state == ST_STORE);
          r_state    <= ST_MEM_WAIT;
        end
        ST_SWAP: r_state <= ST_SWAP_2;
        ST_EXC_ENTRY: begin
          // Straight to fetch: the handler's first instruction always runs.
          r_int_en <= 1'b0;
          r_state  <= ST_FETCH;
        end
        ST_EXC_RETURN, ST_INT_ENABLE: begin
          r_int_en <= 1'b1;
          r_state  <= ST_EXC_CHECK;
        end
        ST_INT_DISABLE: begin
          r_int_en <= 1'b0;
          r_state  <= ST_EXC_CHECK;
        end
        ST_BREAK: r_state <= ST_BREAK;
        default:  r_state <= ST_EXC_CHECK;
      endcase
    end
  end

  // Datapath strobes decoded from the current state and the decoder fields.
  always_comb begin
    pcWr_o       = 1'b0;
    regWr_o      = 1'b0;
    irWr_o       = 1'b0;
    memEn_o      = 1'b0;
    memRW_o      = 1'b0;
    byteOp_o     = 1'b0;
    tempWr_o     = 1'b0;
    epcWr_o      = 1'b0;
    pcSrc_o      = PC_SRC_INC;
    aluBSel_o    = ALU_B_REG;
    regWrSel_o   = REG_WR_ALU;
    regWrAdr_o   = regAdrA_i;
    aluOp_o      = aluOp_i;
    branchOffs_o = jumpOffset_i;
    unique case (r_state)
      ST_FETCH: begin
        memEn_o = 1'b1;
        pcWr_o  = 1'b1;
      end
      ST_FETCH_WAIT: irWr_o = !memBusy_i;
      ST_COND_BRANCH: begin
        branchOffs_o = condOffset_i;
        pcSrc_o      = PC_SRC_BRANCH;
        pcWr_o       = branchRes_i;
      end
      ST_LINK_BRANCH: begin
        // The PC register still holds the incremented PC, which goes to LR.
        pcSrc_o    = PC_SRC_BRANCH;
        pcWr_o     = 1'b1;
        regWr_o    = 1'b1;
        regWrAdr_o = LR_ADR;
        regWrSel_o = REG_WR_PC;
      end
      ST_ALU: begin
        regWr_o   = 1'b1;
        byteOp_o  = byteOp_i;
        aluBSel_o = constSel_i ? ALU_B_CONST : ALU_B_REG;
      end
      ST_IMM_LOAD: begin
        regWr_o    = 1'b1;
        regWrSel_o = REG_WR_IMM;
      end
      ST_LOAD, ST_STORE: begin
        aluBSel_o = ALU_B_MEM;
        memEn_o   = 1'b1;
        memRW_o   = (r_state == ST_STORE);
        byteOp_o  = byteOp_i;
      end
      ST_MEM_WRITEBACK: begin
        regWr_o    = 1'b1;
        regWrSel_o = REG_WR_MEM;
      end
      ST_SWAP: begin
        tempWr_o = 1'b1;
        regWr_o  = 1'b1;
      end
      ST_SWAP_2: begin
        regWrAdr_o = regAdrB_i;
        regWrSel_o = REG_WR_TEMP;
        regWr_o    = 1'b1;
      end
      ST_EXC_ENTRY: begin
        epcWr_o = 1'b1;
        pcSrc_o = PC_SRC_VECTOR;
        pcWr_o  = 1'b1;
      end
      ST_EXC_RETURN: begin
        pcSrc_o = PC_SRC_EPC;
        pcWr_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xm_mc_controller.sv
// Directed bench for xm_mc_controller. Each instruction is expanded into the
// cycle-by-cycle strobe pattern it must produce; a negedge process compares.
module tb_xm_mc_controller;
  import xm_mc_pkg::*;

  localparam int MEM_TIMEOUT = 15;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b0;
  logic        memBusy_i = 1'b0;
  logic [3:0]  instClass_i = 4'd0;
  logic        branchRes_i = 1'b0, constSel_i = 1'b0, byteOp_i = 1'b0;
  logic [2:0]  regAdrA_i = 3'd0, regAdrB_i = 3'd0;
  logic [3:0]  aluOp_i = 4'd0;
  logic [15:0] condOffset_i = 16'd0, jumpOffset_i = 16'd0;
  logic [3:0]  irq_i = 4'd0;
  logic        pcWr_o, regWr_o, irWr_o, memEn_o, memRW_o, byteOp_o, tempWr_o, epcWr_o, intEn_o;
  logic [1:0]  pcSrc_o, aluBSel_o;
  logic [2:0]  regWrSel_o, regWrAdr_o, regAdrA_o, regAdrB_o;
  logic [3:0]  aluOp_o, excVec_o;
  logic [15:0] branchOffs_o;

  xm_mc_controller #(.WORD(16), .LR(5), .NUM_IRQ(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .memBusy_i(memBusy_i), .instClass_i(instClass_i),
    .branchRes_i(branchRes_i), .constSel_i(constSel_i), .byteOp_i(byteOp_i),
    .regAdrA_i(regAdrA_i), .regAdrB_i(regAdrB_i), .aluOp_i(aluOp_i),
    .condOffset_i(condOffset_i), .jumpOffset_i(jumpOffset_i), .irq_i(irq_i),
    .pcWr_o(pcWr_o), .regWr_o(regWr_o), .irWr_o(irWr_o), .memEn_o(memEn_o),
    .memRW_o(memRW_o), .byteOp_o(byteOp_o), .pcSrc_o(pcSrc_o), .aluBSel_o(aluBSel_o),
    .regWrSel_o(regWrSel_o), .regWrAdr_o(regWrAdr_o), .regAdrA_o(regAdrA_o),
    .regAdrB_o(regAdrB_o), .aluOp_o(aluOp_o), .branchOffs_o(branchOffs_o),
    .tempWr_o(tempWr_o), .excVec_o(excVec_o), .epcWr_o(epcWr_o), .intEn_o(intEn_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        pc_wr, reg_wr, ir_wr, mem_en, mem_rw, byte_op, temp_wr, epc_wr, int_en;
    logic [1:0]  pc_src, alu_b_sel;
    logic [2:0]  reg_wr_sel, reg_wr_adr, adr_a, adr_b;
    logic [3:0]  alu_op, exc_vec;
    logic [15:0] br_offs;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cycle  = 0;
  exp_t exp_cur;
  bit   exp_valid = 1'b0;

  // Architectural model state
  logic       m_int_en  = 1'b0;
  logic [3:0] m_exc_vec = 4'd0;
  bit         m_resume  = 1'b0;   // an exception entry left the core heading into fetch

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, req, n_cycle, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Idle cycle: no strobes, pass-through fields, current model registers.
  function automatic exp_t base();
    exp_t e;
    e.pc_wr = 0; e.reg_wr = 0; e.ir_wr = 0; e.mem_en = 0; e.mem_rw = 0;
    e.byte_op = 0; e.temp_wr = 0; e.epc_wr = 0;
    e.pc_src = 2'd0; e.alu_b_sel = 2'd0; e.reg_wr_sel = 3'd0;
    e.reg_wr_adr = regAdrA_i; e.adr_a = regAdrA_i; e.adr_b = regAdrB_i;
    e.alu_op = aluOp_i; e.br_offs = jumpOffset_i;
    e.int_en = m_int_en; e.exc_vec = m_exc_vec;
    return e;
  endfunction

  task automatic step(input exp_t e);
    exp_cur = e;
    exp_valid = 1'b1;
    @(posedge clk_i);
    #1;
    n_cycle++;
  endtask

  // Single compare process against the expected pattern of the current cycle.
  always @(negedge clk_i) begin
    if (exp_valid) begin
      check("pcWr",       32'(pcWr_o),       32'(exp_cur.pc_wr));
      check("regWr",      32'(regWr_o),      32'(exp_cur.reg_wr));
      check("irWr",       32'(irWr_o),       32'(exp_cur.ir_wr));
      check("memEn",      32'(memEn_o),      32'(exp_cur.mem_en));
      check("memRW",      32'(memRW_o),      32'(exp_cur.mem_rw));
      check("byteOp",     32'(byteOp_o),     32'(exp_cur.byte_op));
      check("tempWr",     32'(tempWr_o),     32'(exp_cur.temp_wr));
      check("epcWr",      32'(epcWr_o),      32'(exp_cur.epc_wr));
      check("intEn",      32'(intEn_o),      32'(exp_cur.int_en));
      check("pcSrc",      32'(pcSrc_o),      32'(exp_cur.pc_src));
      check("aluBSel",    32'(aluBSel_o),    32'(exp_cur.alu_b_sel));
      check("regWrSel",   32'(regWrSel_o),   32'(exp_cur.reg_wr_sel));
      check("regWrAdr",   32'(regWrAdr_o),   32'(exp_cur.reg_wr_adr));
      check("regAdrA",    32'(regAdrA_o),    32'(exp_cur.adr_a));
      check("regAdrB",    32'(regAdrB_o),    32'(exp_cur.adr_b));
      check("aluOp",      32'(aluOp_o),      32'(exp_cur.alu_op));
      check("excVec",     32'(excVec_o),     32'(exp_cur.exc_vec));
      check("branchOffs", 32'(branchOffs_o), 32'(exp_cur.br_offs));
    end
  end

  task automatic do_entry();
    exp_t e;
    e = base(); e.epc_wr = 1; e.pc_src = 2'd2; e.pc_wr = 1;
    step(e);
    m_int_en = 1'b0;
    m_resume = 1'b1;
  endtask

  // Memory wait: n_busy busy cycles, then one ready cycle; the MEM_TIMEOUT-th
  // consecutive busy cycle is a bus fault instead.
  task automatic mem_wait(input int n_busy, input bit is_fetch, output bit fault);
    exp_t e;
    fault = 1'b0;
    for (int k = 0; k < n_busy && !fault; k++) begin
      memBusy_i = 1'b1;
      e = base(); step(e);
      if (k + 1 == MEM_TIMEOUT) fault = 1'b1;
    end
    memBusy_i = 1'b0;
    if (fault) begin
      m_exc_vec = EXC_BUSFAULT;
      do_entry();
    end else begin
      e = base(); e.ir_wr = is_fetch; step(e);
    end
  endtask

  // One instruction from the between-instructions check to its last execute cycle.
  task automatic run(input logic [3:0] cls, input int fb = 0, input int mb = 0,
                     input logic [3:0] irq_f = 4'd0, input logic [3:0] irq_x = 4'd0);
    exp_t e;
    bit   fault;
    instClass_i = cls;
    if (m_resume) begin
      m_resume = 1'b0;
    end else begin
      e = base(); step(e);
      if (m_int_en && irq_i != 4'd0) begin
        m_exc_vec = lowest(irq_i);
        do_entry();
        m_resume = 1'b0;
      end
    end
    irq_i = irq_f;
    e = base(); e.mem_en = 1; e.pc_wr = 1; step(e);
    mem_wait(fb, 1'b1, fault);
    if (fault) return;
    e = base(); step(e);
    irq_i = irq_x;
    e = base();
    case (cls)
      CLS_ALU: begin
        e.reg_wr = 1; e.byte_op = byteOp_i; e.alu_b_sel = constSel_i ? 2'd1 : 2'd0; step(e);
      end
      CLS_IMM_LOAD: begin e.reg_wr = 1; e.reg_wr_sel = 3'd3; step(e); end
      CLS_COND_BRANCH: begin
        e.br_offs = condOffset_i; e.pc_src = 2'd1; e.pc_wr = branchRes_i; step(e);
      end
      CLS_LINK_BRANCH: begin
        e.pc_src = 2'd1; e.pc_wr = 1; e.reg_wr = 1; e.reg_wr_adr = 3'd5; e.reg_wr_sel = 3'd1; step(e);
      end
      CLS_LOAD, CLS_STORE: begin
        e.alu_b_sel = 2'd2; e.mem_en = 1; e.mem_rw = (cls == CLS_STORE); e.byte_op = byteOp_i;
        step(e);
        mem_wait(mb, 1'b0, fault);
        if (!fault && cls == CLS_LOAD) begin
          e = base(); e.reg_wr = 1; e.reg_wr_sel = 3'd2; step(e);
        end
      end
      CLS_SWAP: begin
        e.temp_wr = 1; e.reg_wr = 1; step(e);
        e = base(); e.reg_wr_adr = regAdrB_i; e.reg_wr_sel = 3'd4; e.reg_wr = 1; step(e);
      end
      CLS_RETI:        begin e.pc_src = 2'd3; e.pc_wr = 1; step(e); m_int_en = 1'b1; end
      CLS_INT_ENABLE:  begin step(e); m_int_en = 1'b1; end
      CLS_INT_DISABLE: begin step(e); m_int_en = 1'b0; end
      CLS_BREAK:       repeat (6) step(e);
      default: begin m_exc_vec = EXC_ILLEGAL; do_entry(); end
    endcase
  endtask

  // Start a load, then pull reset low in the middle of its memory wait.
  task automatic abort_load();
    exp_t e;
    instClass_i = CLS_LOAD;
    e = base(); step(e);
    e = base(); e.mem_en = 1; e.pc_wr = 1; step(e);
    e = base(); e.ir_wr = 1; step(e);
    e = base(); step(e);
    e = base(); e.alu_b_sel = 2'd2; e.mem_en = 1; e.byte_op = byteOp_i; step(e);
    memBusy_i = 1'b1;
    e = base(); step(e);
    exp_valid = 1'b0;
    #2 arst_i = 1'b0;
    #1;
    check("abort_memEn", 32'(memEn_o), 32'd0);
    check("abort_regWr", 32'(regWr_o), 32'd0);
    check("abort_pcWr",  32'(pcWr_o),  32'd0);
    check("abort_excVec", 32'(excVec_o), 32'd0);
    @(posedge clk_i); #1;
    check("abort_irWr",  32'(irWr_o),  32'd0);
    check("abort_epcWr", 32'(epcWr_o), 32'd0);
    memBusy_i = 1'b0;
    arst_i = 1'b1;
    m_int_en = 1'b0; m_exc_vec = 4'd0; m_resume = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_pcWr",   32'(pcWr_o),   32'd0);
    check("rst_memEn",  32'(memEn_o),  32'd0);
    check("rst_intEn",  32'(intEn_o),  32'd0);
    check("rst_excVec", 32'(excVec_o), 32'd0);
    arst_i = 1'b1;

    // Basic execute classes
    aluOp_i = 4'h3; regAdrA_i = 3'd1; regAdrB_i = 3'd4; constSel_i = 1'b1;
    run(CLS_ALU);
    constSel_i = 1'b0; byteOp_i = 1'b1;
    run(CLS_ALU);
    regAdrA_i = 3'd7;
    run(CLS_LOAD, 0, 3);
    byteOp_i = 1'b0;
    run(CLS_STORE, 0, 2);
    run(CLS_IMM_LOAD);
    condOffset_i = 16'h0010; jumpOffset_i = 16'hFF80; branchRes_i = 1'b0;
    run(CLS_COND_BRANCH);
    branchRes_i = 1'b1;
    run(CLS_COND_BRANCH);
    run(CLS_LINK_BRANCH);
    regAdrA_i = 3'd2; regAdrB_i = 3'd6;
    run(CLS_SWAP);

    // Interrupts
    run(CLS_INT_ENABLE);
    run(CLS_ALU, 0, 0, 4'd0, 4'b1010);    // raised during execute
    run(CLS_ALU);                          // taken at the next check
    check("irq_vec",   32'(excVec_o), 32'd1);
    check("irq_intEn", 32'(intEn_o),  32'd0);
    run(CLS_RETI);
    check("reti_intEn", 32'(intEn_o), 32'd1);
    run(CLS_ALU, 0, 0, 4'b0100, 4'd0);    // gone before the check
    run(CLS_IMM_LOAD);
    check("pulse_vec", 32'(excVec_o), 32'd1);
    run(CLS_ALU, 0, 0, 4'd0, 4'b1100);    // simultaneous requests
    run(CLS_IMM_LOAD);
    check("simul_vec", 32'(excVec_o), 32'd2);
    run(CLS_RETI);
    run(CLS_INT_DISABLE, 0, 0, 4'd0, 4'b0001);
    run(CLS_ALU);
    check("masked_vec", 32'(excVec_o), 32'd2);

    // Memory timeout boundary
    run(CLS_INT_ENABLE);
    run(CLS_ALU, MEM_TIMEOUT - 1);
    check("fetch_ok_vec", 32'(excVec_o), 32'd2);
    run(CLS_ALU, MEM_TIMEOUT);
    check("fetch_to_vec",   32'(excVec_o), 32'd9);
    check("fetch_to_intEn", 32'(intEn_o),  32'd0);
    run(CLS_ALU);
    run(CLS_LOAD, 0, MEM_TIMEOUT - 1);
    run(CLS_LOAD, 0, MEM_TIMEOUT);
    check("mem_to_vec", 32'(excVec_o), 32'd9);
    run(CLS_ALU);

    // Undefined classes
    run(4'd15);
    check("illegal15_vec", 32'(excVec_o), 32'd8);
    run(CLS_ALU);
    run(4'd11);
    run(CLS_STORE, 0, 1);

    // Reset during a memory access, then normal operation again
    abort_load();
    run(CLS_ALU);
    run(CLS_BREAK);
    exp_valid = 1'b0;
    check("break_memEn", 32'(memEn_o), 32'd0);
    check("break_pcWr",  32'(pcWr_o),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
